// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit -- hardware operand stack (LIFO) for the processor datapath.
//
// Executes the single-cycle push/pop/tos strobes from the controller. The
// popped or peeked word is returned on a registered output. Occupancy and
// error status are also reported.
//
// Parameters
//   WIDTH      data word width in bits
//   DEPTH      capacity in words (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset (wins over any strobe)
//   push       write din onto the stack
//   pop        remove the top word and return it on dout
//   tos        return the top word on dout without removing it
//   din        data to push
//   dout       registered read data from the last pop/tos/replace
//   empty      count == 0 (registered)
//   full       count == DEPTH (registered)
//   count      number of words held (registered)
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop or tos attempted while empty
//
// Build option
//   STACK_CHECK_EN  when defined, full/empty protection and sticky
//                   overflow/underflow flags are enabled. When undefined, the
//                   stack pointer wraps modulo DEPTH and both flags read 0.
//                   count still saturates, so full/empty stay meaningful.
// ---------------------------------------------------------------------------
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    tos,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_PUSH,
    CMD_POP,
    CMD_TOS,
    CMD_REPLACE
  } cmd_e;

  cmd_e             cmd;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, full_q;
  logic [AW-1:0]    sp_lo, top_slot, wr_addr;
  logic             wr_en;
  logic             is_empty, is_full;

`ifdef STACK_CHECK_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  // With protection the pointer never wraps, so count doubles as sp.
  // At count == DEPTH the low bits read 0 and top_slot still lands on DEPTH-1.
  assign sp_lo = count_q[AW-1:0];
`else
  logic [AW-1:0] sp_q, sp_d;
  assign sp_lo = sp_q;
`endif

  assign top_slot = sp_lo - AW'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Priority decode. A replace on an empty stack has no top word to return,
  // so it degrades to a plain push.
  always_comb begin
    cmd = CMD_IDLE;
    if (push && pop)  cmd = is_empty ? CMD_PUSH : CMD_REPLACE;
    else if (push)    cmd = CMD_PUSH;
    else if (pop)     cmd = CMD_POP;
    else if (tos)     cmd = CMD_TOS;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    wr_addr = sp_lo;
`ifdef STACK_CHECK_EN
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`else
    sp_d    = sp_q;
`endif
    case (cmd)
      CMD_REPLACE: begin
        wr_en   = 1'b1;
        wr_addr = top_slot;
        dout_d  = mem[top_slot];
      end
      CMD_PUSH: begin
`ifdef STACK_CHECK_EN
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
`else
        wr_en   = 1'b1;
        sp_d    = sp_lo + AW'(1);
        count_d = is_full ? count_q : count_q + CW'(1);
`endif
      end
      CMD_POP: begin
`ifdef STACK_CHECK_EN
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          dout_d  = mem[top_slot];
          count_d = count_q - CW'(1);
        end
`else
        dout_d  = mem[top_slot];
        sp_d    = top_slot;
        count_d = is_empty ? count_q : count_q - CW'(1);
`endif
      end
      CMD_TOS: begin
`ifdef STACK_CHECK_EN
        if (is_empty) unf_d = 1'b1;
        else          dout_d = mem[top_slot];
`else
        dout_d = mem[top_slot];
`endif
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      dout_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
`ifdef STACK_CHECK_EN
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`else
      sp_q    <= '0;
`endif
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
`ifdef STACK_CHECK_EN
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`else
      sp_q    <= sp_d;
`endif
    end
  end

  // NOTE: the storage array is deliberately not reset. Reset only clears the
  // pointer, and the write is gated by rst so reset still beats a push.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_addr] <= din;
  end

  assign dout  = dout_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;
`ifdef STACK_CHECK_EN
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit -- self-checking bench for stack_unit.
//
// Each driven command updates a behavioural stack model. Every read command
// (pop, tos, replace) also pushes its expected word onto a scoreboard queue.
// That word is popped and compared against dout one edge later.
// ---------------------------------------------------------------------------
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             p;
    logic             q;
    logic             t;
    logic [WIDTH-1:0] d;
  } op_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0, pop = 1'b0, tos = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             empty, full, overflow, underflow;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .din       (din),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [WIDTH-1:0] exp_q [$];

  // Behavioural model. Its contents survive reset, just like the array.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_sp, m_cnt;
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf, m_unf;

  task automatic model_reset();
    m_sp = 0; m_cnt = 0; m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_read(input int top);
    m_dout = m_mem[top];
    exp_q.push_back(m_mem[top]);
  endtask

  task automatic model_step(input op_t o);
    int top;
    top = (m_sp + DEPTH - 1) % DEPTH;
    if (o.p && o.q && m_cnt != 0) begin
      model_read(top);
      m_mem[top] = o.d;
    end else if (o.p) begin
`ifdef STACK_CHECK_EN
      if (m_cnt == DEPTH) m_ovf = 1'b1;
      else begin m_mem[m_sp] = o.d; m_sp++; m_cnt++; end
`else
      m_mem[m_sp] = o.d;
      m_sp = (m_sp + 1) % DEPTH;
      if (m_cnt < DEPTH) m_cnt++;
`endif
    end else if (o.q || o.t) begin
`ifdef STACK_CHECK_EN
      if (m_cnt == 0) m_unf = 1'b1;
      else begin
        model_read(top);
        if (o.q) begin m_sp--; m_cnt--; end
      end
`else
      model_read(top);
      if (o.q) begin
        m_sp = top;
        if (m_cnt > 0) m_cnt--;
      end
`endif
    end
  endtask

  // Drive one command for one cycle. Outputs settle #1 after the edge.
  task automatic apply(input op_t o);
    @(negedge clk);
    push = o.p; pop = o.q; tos = o.t; din = o.d;
    model_step(o);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; tos = 1'b0;
  endtask

  function automatic op_t mk(input logic p, input logic q, input logic t,
                             input logic [WIDTH-1:0] d);
    op_t o;
    o.p = p; o.q = q; o.t = t; o.d = d;
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (empty !== 1'b1)     begin n_miss++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (full !== 1'b0)      begin n_miss++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (count !== '0)       begin n_miss++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (dout !== '0)        begin n_miss++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_vec++; if (overflow !== 1'b0)  begin n_miss++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_vec++; if (underflow !== 1'b0) begin n_miss++; $display("FAIL reset_unf: got %b want 0", underflow); end
  endtask

  task automatic test_lifo();
    op_t seq [$];
    logic [WIDTH-1:0] e;
    seq.push_back(mk(1, 0, 0, 8'h11));
    seq.push_back(mk(1, 0, 0, 8'h22));
    seq.push_back(mk(1, 0, 0, 8'h33));
    seq.push_back(mk(0, 1, 0, 8'h00));
    seq.push_back(mk(0, 1, 0, 8'h00));
    seq.push_back(mk(0, 1, 0, 8'h00));
    foreach (seq[i]) begin
      apply(seq[i]);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++; if (dout !== e) begin n_miss++; $display("FAIL lifo_dout step %0d: got %h want %h", i, dout, e); end
      end
      n_vec++; if (count !== CW'(m_cnt)) begin n_miss++; $display("FAIL lifo_count step %0d: got %0d want %0d", i, count, m_cnt); end
    end
    n_vec++; if (dout !== 8'h11)  begin n_miss++; $display("FAIL lifo_last: got %h want 11", dout); end
    n_vec++; if (empty !== 1'b1) begin n_miss++; $display("FAIL lifo_empty: got %b want 1", empty); end
  endtask

  task automatic test_tos();
    op_t seq [$];
    logic [WIDTH-1:0] e;
    seq.push_back(mk(1, 0, 0, 8'hA5));
    seq.push_back(mk(0, 0, 1, 8'h00));
    seq.push_back(mk(0, 0, 1, 8'h00));
    seq.push_back(mk(1, 0, 1, 8'h3C));  // tos ignored under push
    seq.push_back(mk(0, 0, 1, 8'h00));  // back-to-back push then tos
    seq.push_back(mk(0, 1, 0, 8'h00));
    seq.push_back(mk(0, 1, 0, 8'h00));
    foreach (seq[i]) begin
      apply(seq[i]);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++; if (dout !== e) begin n_miss++; $display("FAIL tos_dout step %0d: got %h want %h", i, dout, e); end
      end
      n_vec++; if (count !== CW'(m_cnt)) begin n_miss++; $display("FAIL tos_count step %0d: got %0d want %0d", i, count, m_cnt); end
      if (i == 2) begin
        n_vec++; if (count !== CW'(1)) begin n_miss++; $display("FAIL tos_hold: got %0d want 1", count); end
      end
    end
  endtask

  task automatic test_replace();
    op_t seq [$];
    logic [WIDTH-1:0] e;
    seq.push_back(mk(1, 0, 0, 8'h01));
    seq.push_back(mk(1, 1, 0, 8'h02));
    seq.push_back(mk(0, 1, 0, 8'h00));
    seq.push_back(mk(1, 1, 0, 8'h5E));  // replace on empty acts as push
    seq.push_back(mk(0, 1, 0, 8'h00));
    foreach (seq[i]) begin
      apply(seq[i]);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++; if (dout !== e) begin n_miss++; $display("FAIL repl_dout step %0d: got %h want %h", i, dout, e); end
      end
      n_vec++; if (count !== CW'(m_cnt)) begin n_miss++; $display("FAIL repl_count step %0d: got %0d want %0d", i, count, m_cnt); end
      if (i == 2) begin
        n_vec++; if (dout !== 8'h02) begin n_miss++; $display("FAIL repl_final: got %h want 02", dout); end
      end
    end
  endtask

  task automatic test_full_empty();
    logic [WIDTH-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      apply(mk(1, 0, 0, WIDTH'(8'h40 + i)));
      n_vec++; if (full !== (m_cnt == DEPTH)) begin n_miss++; $display("FAIL fill_full %0d: got %b want %b", i, full, (m_cnt == DEPTH)); end
    end
    n_vec++; if (count !== CW'(DEPTH)) begin n_miss++; $display("FAIL fill_count: got %0d want %0d", count, DEPTH); end
    apply(mk(1, 0, 0, 8'hFF));
    n_vec++; if (full !== 1'b1)          begin n_miss++; $display("FAIL ovf_full: got %b want 1", full); end
    n_vec++; if (count !== CW'(DEPTH))   begin n_miss++; $display("FAIL ovf_count: got %0d want %0d", count, DEPTH); end
    n_vec++; if (overflow !== m_ovf)     begin n_miss++; $display("FAIL ovf_flag: got %b want %b", overflow, m_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      apply(mk(0, 1, 0, 8'h00));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++; if (dout !== e) begin n_miss++; $display("FAIL drain_dout %0d: got %h want %h", i, dout, e); end
      end
      n_vec++; if (count !== CW'(m_cnt)) begin n_miss++; $display("FAIL drain_count %0d: got %0d want %0d", i, count, m_cnt); end
    end
    n_vec++; if (empty !== 1'b1) begin n_miss++; $display("FAIL drain_empty: got %b want 1", empty); end
    apply(mk(0, 1, 0, 8'h00));
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    n_vec++; if (underflow !== m_unf) begin n_miss++; $display("FAIL unf_flag: got %b want %b", underflow, m_unf); end
    n_vec++; if (dout !== m_dout)     begin n_miss++; $display("FAIL unf_dout: got %h want %h", dout, m_dout); end
    n_vec++; if (count !== '0)        begin n_miss++; $display("FAIL unf_count: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] e;
    for (int i = 0; i < 5; i++) apply(mk(1, 0, 0, WIDTH'(8'h80 + i)));
    @(negedge clk);
    rst = 1'b0; push = 1'b1; din = 8'hEE;
    model_reset();
    @(posedge clk);
    #1;
    push = 1'b0; rst = 1'b1;
    n_vec++; if (count !== '0)        begin n_miss++; $display("FAIL mid_count: got %0d want 0", count); end
    n_vec++; if (empty !== 1'b1)      begin n_miss++; $display("FAIL mid_empty: got %b want 1", empty); end
    n_vec++; if (dout !== '0)         begin n_miss++; $display("FAIL mid_dout: got %h want 00", dout); end
    n_vec++; if (overflow !== 1'b0)   begin n_miss++; $display("FAIL mid_ovf: got %b want 0", overflow); end
    n_vec++; if (underflow !== 1'b0)  begin n_miss++; $display("FAIL mid_unf: got %b want 0", underflow); end
    apply(mk(1, 0, 0, 8'h99));
    apply(mk(0, 0, 1, 8'h00));
    e = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
    n_vec++; if (dout !== e)          begin n_miss++; $display("FAIL mid_tos: got %h want %h", dout, e); end
    n_vec++; if (count !== CW'(1))    begin n_miss++; $display("FAIL mid_restart: got %0d want 1", count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lifo();
    test_tos();
    test_replace();
    test_full_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack that executes the push/pop/tos strobes issued by the processor controller. It is the responder side of the controller's stack-command interface and sits inside the datapath between the memory-data and ALU operand registers. It holds up to DEPTH words, returns the popped or peeked word on a registered output, and reports occupancy and error status.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 16, stack capacity in words; power of two, at least 2
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-low reset
- push  input  1  write din onto the stack this cycle
- pop  input  1  remove the top word and return it on dout
- tos  input  1  return the top word on dout without removing it
- din  input  WIDTH  data to push
- dout  output  WIDTH  registered read data from the last pop/tos
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  $clog2(DEPTH)+1  number of words held
- overflow  output  1  sticky: a push was attempted while full
- underflow  output  1  sticky: a pop or tos was attempted while empty

## Operation
- Storage: DEPTH x WIDTH register array. Stack pointer sp = count; the top word is at mem[sp-1].
- Command decode per cycle, in priority order:
  - push & pop: replace top. mem[sp-1] <= din, dout <= old mem[sp-1], sp unchanged. If empty, act as a plain push, with dout unchanged and no underflow.
  - push only: if not full, mem[sp] <= din and sp <= sp+1. If full, the stack is unchanged and overflow <= 1.
  - pop only: if not empty, dout <= mem[sp-1] and sp <= sp-1. If empty, sp and dout are unchanged and underflow <= 1.
  - tos only (or tos with no other strobe): if not empty, dout <= mem[sp-1]. If empty, dout is unchanged and underflow <= 1.
  - tos asserted together with push or pop is ignored; the higher-priority command executes.
  - No strobe: all state holds.
- empty, full and count are registered and derived from the next sp. They are never combinational from the strobes.
- overflow and underflow stay set until reset.

## Timing
- All outputs change only on the rising edge of clk.
- dout is valid the cycle after the pop/tos strobe and holds until the next successful pop, tos or replace.
- A pushed word is readable by tos or pop in the very next cycle (back-to-back push then tos returns the new word).
- Throughput: one command per cycle, with no stall and no handshake. The controller guarantees strobes are single-cycle per operation.
- Reset, applied when rst == 0 at a clock edge: sp=0, count=0, empty=1, full=0, dout=0, overflow=0, underflow=0. Array contents are not cleared.
- Reset wins over any strobe sampled at the same edge. Reset mid-sequence discards the stack.
- Wrap boundaries: count goes from DEPTH-1 to DEPTH on push (full rises), and from 1 to 0 on pop (empty rises), in the same cycle as the update.

## Configuration
- STACK_CHECK_EN defined:
  - Full/empty protection as described above.
  - Overflow/underflow flags are live.
- STACK_CHECK_EN undefined:
  - No protection logic.
  - sp is a $clog2(DEPTH)-bit counter that wraps modulo DEPTH, so a push when full overwrites mem[0] region order, and a pop when empty wraps to DEPTH-1.
  - overflow and underflow are tied to 0.
  - full and empty are still reported, computed from a separate count that saturates.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then release -> empty=1, full=0, count=0, dout=0, flags 0.
- Push 0x11, 0x22, 0x33, then pop x3 -> dout sequence 0x33, 0x22, 0x11, each one cycle after its pop; count goes 3 to 0 and empty=1 at the end.
- Push 0xA5, tos twice -> dout=0xA5 both times; count stays 1.
- Push 0x01, then push&pop with din=0x02, then pop -> the replace cycle gives dout=0x01 and count=1; the final pop gives dout=0x02.
- With STACK_CHECK_EN: 16 pushes (DEPTH=16), then a 17th push of 0xFF -> full=1, count=16, overflow=1, and popping returns the 16th word, not 0xFF. Pop when empty -> underflow=1, dout unchanged.
- Reset mid-operation: after 5 pushes, assert rst=0 together with push -> count=0, empty=1, and no word is written.
